// File: rtl/conv_frame_ctrl_pkg.sv
// Shared frame geometry and sequencer state encodings for the convolution front end.
package conv_frame_ctrl_pkg;

   localparam int DEF_WIDTH       = 32;
   localparam int DEF_HEIGHT      = 32;
   localparam int DEF_KERNEL_SIZE = 3;
   localparam int DEF_CNT_W       = 6;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_FILL   = 3'd2,
      ST_STREAM = 3'd3,
      ST_DRAIN  = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/conv_frame_ctrl_pix_pos_counter.sv
// Row/column position of the next pixel to be accepted; wraps columns at WIDTH.
module pix_pos_counter
   import conv_frame_ctrl_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] row,
   output logic [CNT_W-1:0] col,
   output logic             last_col,
   output logic             last_pix
);

   assign last_col = (col == CNT_W'(WIDTH - 1));
   assign last_pix = last_col && (row == CNT_W'(HEIGHT - 1));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         row <= '0;
         col <= '0;
      end else if (inc) begin
         if (last_col) begin
            col <= '0;
            row <= row + CNT_W'(1);
         end else begin
            col <= col + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer: clears the line buffer, meters pixels in, and qualifies
// buffer outputs as complete windows with conv-engine backpressure.
module conv_frame_ctrl
   import conv_frame_ctrl_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int HEIGHT      = DEF_HEIGHT,
   parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic             src_valid,
   output logic             src_ready,
   output logic             buf_rstb,
   output logic             buf_read_valid,
   output logic             buf_win_ready,
   output logic             win_valid,
   input  logic             win_ready,
   output logic [CNT_W-1:0] win_row,
   output logic [CNT_W-1:0] win_col,
   output logic             win_last
);

   localparam logic [CNT_W-1:0] K_M1    = CNT_W'(KERNEL_SIZE - 1);
   localparam logic [CNT_W-1:0] ROW_END = CNT_W'(HEIGHT - 1);

   state_t           state;
   logic [CNT_W-1:0] row;
   logic [CNT_W-1:0] col;
   logic             last_col;
   logic             last_pix;
   logic             pos_clear;
   logic             accept;
   logic             qualify;
   logic             frame_end;

   assign busy           = (state != ST_IDLE);
   assign buf_rstb       = !(rst || state == ST_CLEAR);
   assign src_ready      = (state == ST_FILL || state == ST_STREAM) && (!win_valid || win_ready);
   assign accept         = src_valid && src_ready;
   assign buf_read_valid = accept;
   assign buf_win_ready  = src_ready;
   assign pos_clear      = (state == ST_CLEAR);

   // A pixel completes a window once it sits at or beyond the kernel's bottom-right corner.
   assign qualify   = (row >= K_M1) && (col >= K_M1);
   assign frame_end = accept && last_col && (row == ROW_END);

   pix_pos_counter #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .CNT_W  (CNT_W)
   ) u_pos (
      .clk      (clk),
      .rst      (rst),
      .clear    (pos_clear),
      .inc      (accept),
      .row      (row),
      .col      (col),
      .last_col (last_col),
      .last_pix (last_pix)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         done      <= 1'b0;
         win_valid <= 1'b0;
         win_last  <= 1'b0;
         win_row   <= '0;
         win_col   <= '0;
      end else begin
         done <= 1'b0;

         // An accept can only happen when any held window is being consumed,
         // so the new pixel alone decides whether a window follows.
         if (state == ST_CLEAR) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
         end else if (accept) begin
            win_valid <= qualify;
            if (qualify) begin
               win_row  <= row - K_M1;
               win_col  <= col - K_M1;
               win_last <= last_pix;
            end
         end else if (win_valid && win_ready) begin
            win_valid <= 1'b0;
         end

         case (state)
            ST_IDLE:   if (start) state <= ST_CLEAR;
            ST_CLEAR:  state <= ST_FILL;
            ST_FILL: begin
               if (frame_end)
                  state <= ST_DRAIN;
               else if (accept && row == K_M1)
                  state <= ST_STREAM;
            end
            ST_STREAM: if (frame_end) state <= ST_DRAIN;
            ST_DRAIN: begin
               if (!win_valid || win_ready) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            ST_DONE:   state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

endmodule
